// File: rtl/inc_share_pkg.sv
// Shared encodings and default sizes for the shared-incrementer arbiter.
package inc_share_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_IDW   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/inc_share_arb_inc.sv
// Plain WIDTH-bit incrementer; the carry-out is dropped (result wraps modulo 2^WIDTH).
module inc_share_inc #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = a + WIDTH'(1);

endmodule

// File: rtl/inc_share_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_valid
);

  int idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any_valid && req[idx]) begin
        any_valid    = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/inc_share_arb.sv
// One incrementer shared by NREQ requesters through a round-robin IDLE/EXEC/RESP FSM.
// Optional carry-out output rsp_ovf is enabled by defining INC_SHARE_OVF_EN.
module inc_share_arb
  import inc_share_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = DEF_IDW
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  input  logic                  rsp_ready,
  output state_e                dbg_state
`ifdef INC_SHARE_OVF_EN
  ,output logic                 rsp_ovf
`endif
);

  // Handshake: a transfer happens on a rising Clk edge where valid and ready
  // are both high; valid/data are held by the source until that edge.

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             rsp_valid_q, rsp_valid_d;
`ifdef INC_SHARE_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any_valid;
  logic [WIDTH-1:0] inc_y;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_valid (any_valid)
  );

  inc_share_inc #(.WIDTH(WIDTH)) u_inc (
    .a (opnd_q),
    .y (inc_y)
  );

  // Reset also masks ready so nothing looks accepted while the block is held.
  assign req_ready = (state_q == IDLE && !Rst) ? gnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = res_q;
  assign dbg_state = state_q;
`ifdef INC_SHARE_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    opnd_d      = opnd_q;
    id_d        = id_q;
    res_d       = res_q;
    rsp_valid_d = rsp_valid_q;
`ifdef INC_SHARE_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          opnd_d  = req_data[gnt_idx*WIDTH +: WIDTH];
          id_d    = gnt_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d       = inc_y;
        rsp_valid_d = 1'b1;
`ifdef INC_SHARE_OVF_EN
        ovf_d       = &opnd_q;
`endif
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (int'(id_q) == NREQ - 1) ? '0 : id_q + IDW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      opnd_q      <= '0;
      id_q        <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
`ifdef INC_SHARE_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      opnd_q      <= opnd_d;
      id_q        <= id_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef INC_SHARE_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_inc_share_arb.sv
// Bench for inc_share_arb: directed vector table, corner sequences, random run vs transaction model.
module tb_inc_share_arb;
  import inc_share_pkg::*;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_ready;
  state_e          dbg_state;
`ifdef INC_SHARE_OVF_EN
  logic            rsp_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         id;
    logic [W-1:0] opnd;
    logic [W-1:0] exp_data;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[6];

  // scoreboard entries: {ovf, id, data}
  logic [W+IW:0] exp_q[$];

  inc_share_arb #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .dbg_state (dbg_state)
`ifdef INC_SHARE_OVF_EN
    ,.rsp_ovf  (rsp_ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return W'($urandom_range(0, 15));
      2:       return {32'hFFFF_FFFF, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic single(input vec_t v, input string tag);
    @(negedge clk);
    req_valid = onehot(v.id);
    req_data[v.id*W +: W] = v.opnd;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_grant"}, req_ready, onehot(v.id));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk({tag, "_exec_ready"}, req_ready, 0);
    chk({tag, "_exec_rsp_valid"}, rsp_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_id"}, rsp_id, v.id);
    chk({tag, "_rsp_data"}, rsp_data, v.exp_data);
`ifdef INC_SHARE_OVF_EN
    chk({tag, "_rsp_ovf"}, rsp_ovf, v.exp_ovf);
`endif
    @(negedge clk);
    #1;
    chk({tag, "_back_idle"}, rsp_valid, 0);
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [N-1:0] acc;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] opnd;
    logic [W-1:0] exp_d;
    logic [W+IW:0] e;
    int m_ptr, due, g;
    bit busy, found;

    vecs[0] = '{2, 64'h9,                   64'hA,                   1'b0};
    vecs[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b1};
    vecs[2] = '{3, 64'h7,                   64'h8,                   1'b0};
    vecs[3] = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0};
    vecs[4] = '{2, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0};
    vecs[5] = '{3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    // reset state, with requests present to show ready stays low in reset
    rst       = 1'b1;
    req_valid = '1;
    req_data  = '0;
    rsp_ready = 1'b0;
    #12;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_state", dbg_state, IDLE);
`ifdef INC_SHARE_OVF_EN
    chk("reset_rsp_ovf", rsp_ovf, 0);
`endif
    do_reset();

    // table of single operations
    for (int i = 0; i < 6; i++) single(vecs[i], $sformatf("vec%0d", i));

    // round robin with all four held valid
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(64'h100 + i);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      #1;
      chk($sformatf("rr%0d_grant", r), req_ready, onehot(r % N));
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_exec_ready", r), req_ready, 0);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_rsp_id", r), rsp_id, r % N);
      chk($sformatf("rr%0d_rsp_data", r), rsp_data, 64'h101 + (r % N));
      @(negedge clk);
    end
    req_valid = '0;

    // backpressure in RESP with other requesters waiting
    do_reset();
    req_valid = 4'b0010;
    req_data[1*W +: W] = 64'h55;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b1101;
    @(negedge clk);
    for (int h = 0; h < 10; h++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_rsp_data", rsp_data, 64'h56);
      chk("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    chk("bp_release_valid", rsp_valid, 1);
    @(negedge clk);
    #1;
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_ready", req_ready, 0);
    @(negedge clk);
    #1;
    chk("bp_single_rsp", rsp_valid, 0);

    // pointer skip: after serving id 2, requests on 0 and 1
    do_reset();
    single(vecs[0], "skip_pre");
    @(negedge clk);
    req_data[0*W +: W] = 64'h10;
    req_data[1*W +: W] = 64'h20;
    req_valid = 4'b0011;
    rsp_ready = 1'b1;
    #1;
    chk("skip_grant0", req_ready, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("skip_rsp0_id", rsp_id, 0);
    chk("skip_rsp0_data", rsp_data, 64'h11);
    @(negedge clk);
    #1;
    chk("skip_grant1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("skip_rsp1_id", rsp_id, 1);
    chk("skip_rsp1_data", rsp_data, 64'h21);

    // asynchronous reset while in EXEC
    do_reset();
    req_valid = 4'b1000;
    req_data[0*W +: W] = 64'h30;
    req_data[3*W +: W] = 64'h77;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_state", dbg_state, IDLE);
    @(negedge clk);
    #1;
    chk("arst_no_stale", rsp_valid, 0);
    rst = 1'b0;
    #1;
    chk("arst_first_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("arst_exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("arst_rsp_id", rsp_id, 0);
    chk("arst_rsp_data", rsp_data, 64'h31);
    @(negedge clk);

    // randomized run against transaction-level model
    do_reset();
    m_ptr = 0;
    busy  = 1'b0;
    due   = 0;
    exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = req_ready;
      if (!busy) begin
        exp_rdy = '0;
        found   = 1'b0;
        g       = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found = 1'b1;
            g     = (m_ptr + k) % N;
          end
        end
        if (found) exp_rdy = onehot(g);
        chk("rnd_grant", req_ready, exp_rdy);
        chk("rnd_idle_rsp_valid", rsp_valid, 0);
        if (found) begin
          opnd  = req_data[g*W +: W];
          exp_d = opnd + 64'd1;
          exp_q.push_back({(opnd == '1), IW'(g), exp_d});
          busy = 1'b1;
          due  = c + 2;
        end
      end else begin
        chk("rnd_busy_ready", req_ready, 0);
        chk("rnd_rsp_valid", rsp_valid, (c >= due));
        if (rsp_valid && c >= due && exp_q.size() > 0) begin
          e = exp_q[0];
          chk("rnd_rsp_id", rsp_id, e[W +: IW]);
          chk("rnd_rsp_data", rsp_data, e[W-1:0]);
`ifdef INC_SHARE_OVF_EN
          chk("rnd_rsp_ovf", rsp_ovf, e[W+IW]);
`endif
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            m_ptr = (int'(e[W +: IW]) + 1) % N;
            busy  = 1'b0;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_data[i*W +: W] = rand_opnd();
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = rand_opnd();
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 6);
      if (c >= 1480) begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
    end
    chk("rnd_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inc_share_arb.md
Name: inc_share_arb

Overview:
- Shares one WIDTH-bit incrementer datapath (D = A + 1) among NREQ requesters.
- Round-robin arbitration, valid/ready handshake on each request port, and a single registered response channel tagged with the requester id.
- Sits between scheduled datapath states that each need an increment and one physical incrementer instance, saving area versus NREQ incrementers.

Parameters:
- WIDTH, 64, operand/result width in bits (≥1)
- NREQ, 4, number of requesters (2..16)
- IDW, 2, id width; must be ≥ clog2(NREQ)

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  bit i = requester i has an operand
- req_data  input  NREQ*WIDTH  operand i at bits [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  one-hot or zero; bit i = operand i accepted this cycle
- rsp_valid  output  1  result available
- rsp_id  output  IDW  index of requester owning the result
- rsp_data  output  WIDTH  operand + 1, modulo 2^WIDTH
- rsp_ready  input  1  consumer takes the result

Behaviour:
- Clock and reset: one clock, Clk; reset is asynchronous and active-high (Rst).
- Reset values:
  - state = IDLE; rr pointer ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - Operand and id registers = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Combinational grant g = first i with req_valid[i], searching ptr, ptr+1, … mod NREQ.
  - req_ready[g] = 1 only in IDLE and only when some req_valid is set; all other bits 0.
  - On handshake (req_valid[g] & req_ready[g]): capture req_data slice g into opnd_q and g into id_q, then go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - res_q <= opnd_q + 1, truncated to WIDTH; carry-out discarded.
  - Go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1; rsp_data = res_q; rsp_id = id_q. These are registered outputs, stable until the handshake.
  - On rsp_ready: ptr <= (id_q + 1) mod NREQ, then go to IDLE.
  - Otherwise hold indefinitely (backpressure).
- Latency: handshake in cycle N → rsp_valid in cycle N+2. Minimum issue interval is 3 cycles.
- Only one operation is in flight; req_ready stays 0 from acceptance until the cycle after the response handshake.
- Wrap-around:
  - Operand all-ones → rsp_data = 0.
  - ptr at NREQ-1 → next ptr = 0.
- Requester contract: req_data and req_valid must hold until accepted. A requester may deassert req_valid before acceptance; grant is recomputed every IDLE cycle.
- Fairness: a continuously valid requester is granted within NREQ operations.
- Reset mid-operation: the in-flight operand or result is discarded. All state returns to reset values immediately (asynchronous); no response is emitted.
- rsp_data and rsp_id values outside RESP are don't-care for checking. The implementation holds their last values.
- Out-of-range slices: none; NREQ*WIDTH covers all ports exactly.

Optional Feature:
- Macro INC_SHARE_OVF_EN.
- Defined: adds output port rsp_ovf (1 bit).
  - Registered in EXEC as (opnd_q == all-ones), i.e. the carry-out of the increment.
  - Valid with rsp_valid; reset value 0.
- Undefined: port absent and no carry logic; all other behaviour identical.

Decomposition:
- Shared package/header (inc_share_pkg):
  - State encodings: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
  - Default WIDTH/NREQ constants.
- Sub-module rr_arbiter:
  - Inputs: req vector, ptr. Outputs: one-hot grant, encoded index, any-valid.
  - Purely combinational, parameterized by NREQ/IDW.
- Incrementer: the team's existing INC component, instantiated with WIDTH, driving res_q.

Test Plan:
- Single request: req_valid = 4'b0100, data2 = 64'h0000_0000_0000_0009 → req_ready = 4'b0100 for 1 cycle; 2 cycles later rsp_valid = 1, rsp_id = 2, rsp_data = 64'hA; with rsp_ready = 1, back to IDLE.
- Round-robin: all four valid and held, rsp_ready = 1 → grant order 0, 1, 2, 3, 0; each response id matches; one accept per 3 cycles.
- Backpressure: rsp_ready = 0 for 10 cycles during RESP → rsp_valid/rsp_data/rsp_id stable and req_ready = 0 throughout; release → one response only.
- Wrap: operand 64'hFFFF_FFFF_FFFF_FFFF → rsp_data = 0; with INC_SHARE_OVF_EN, rsp_ovf = 1. Operand 64'h7 → rsp_ovf = 0.
- Pointer skip: ptr = 3 (after serving id 2), req_valid = 4'b0011 → grant 0, then 1.
- Async reset in EXEC: assert Rst mid-cycle → rsp_valid and req_ready go 0 immediately; after release, the first grant starts from id 0 and no stale response appears.
